// File: rtl/alu_result_checker_if.sv
// Transaction bus between the ALU under check and alu_result_checker.
// Transfer rule: a transaction moves on a rising edge where in_valid & in_ready are both 1.
interface alu_result_checker_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, a, b, alucontrol, result,
    input  in_ready
  );

  modport slave (
    input  in_valid, a, b, alucontrol, result,
    output in_ready
  );
endinterface

// File: rtl/alu_result_checker.sv
// Two-stage ALU result checker: stage 1 registers the transaction, stage 2 recomputes
// the golden value, judges, updates saturating counters and captures the first mismatch.
module alu_result_checker #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  alu_result_checker_if.slave   bus,
  output logic                  chk_valid,
  output logic                  chk_pass,
  output logic [CNT_W-1:0]      pass_count,
  output logic [CNT_W-1:0]      fail_count,
  output logic [CNT_W-1:0]      illegal_count,
  output logic                  halted,
  output logic                  err_valid,
  output logic [WIDTH-1:0]      err_a,
  output logic [WIDTH-1:0]      err_b,
  output logic [WIDTH-1:0]      err_result,
  output logic [WIDTH-1:0]      err_expected,
  output logic [2:0]            err_ctrl,
  output logic                  dbg_state
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           state;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_ctrl;
  logic [WIDTH-1:0] s1_result;

  logic             take;
  logic             legal;
  logic             slt_bit;
  logic             match;
  logic             mismatch;
  logic             stop_now;
  logic [WIDTH-1:0] expected;

  assign halted    = (state == ST_HALT);
  assign dbg_state = state;

  // Reset and clear both block intake so no transfer can slip past them.
  assign bus.in_ready = !halted && !clear && !reset;
  assign take         = bus.in_valid && bus.in_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign slt_bit = ($signed(s1_a) < $signed(s1_b));

  always_comb begin
    expected = '0;
    legal    = 1'b1;
    case (s1_ctrl)
      3'b000:  expected = s1_a & s1_b;
      3'b001:  expected = s1_a | s1_b;
      3'b010:  expected = s1_a + s1_b;
      3'b011:  expected = s1_a - s1_b;
      3'b101:  expected = {{(WIDTH-1){1'b0}}, slt_bit};
      default: legal    = 1'b0;
    endcase
  end

  assign match    = (expected == s1_result);
  assign mismatch = s1_valid && legal && !match;
  assign stop_now = mismatch && STOP_ON_ERR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_RUN;
      s1_valid      <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_ctrl       <= '0;
      s1_result     <= '0;
      chk_valid     <= 1'b0;
      chk_pass      <= 1'b0;
      pass_count    <= '0;
      fail_count    <= '0;
      illegal_count <= '0;
      err_valid     <= 1'b0;
      err_a         <= '0;
      err_b         <= '0;
      err_result    <= '0;
      err_expected  <= '0;
      err_ctrl      <= '0;
    end else if (clear) begin
      // chk_pass deliberately keeps its last value; only chk_valid is dropped.
      state         <= ST_RUN;
      s1_valid      <= 1'b0;
      chk_valid     <= 1'b0;
      pass_count    <= '0;
      fail_count    <= '0;
      illegal_count <= '0;
      err_valid     <= 1'b0;
      err_a         <= '0;
      err_b         <= '0;
      err_result    <= '0;
      err_expected  <= '0;
      err_ctrl      <= '0;
    end else begin
      chk_valid <= s1_valid;
      if (s1_valid) begin
        chk_pass <= legal && match;
        if (!legal)
          illegal_count <= sat_inc(illegal_count);
        else if (match)
          pass_count <= sat_inc(pass_count);
        else
          fail_count <= sat_inc(fail_count);
      end

      if (mismatch && !err_valid) begin
        err_valid    <= 1'b1;
        err_a        <= s1_a;
        err_b        <= s1_b;
        err_result   <= s1_result;
        err_expected <= expected;
        err_ctrl     <= s1_ctrl;
      end

      case (state)
        ST_RUN:  if (stop_now) state <= ST_HALT;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RUN;
      endcase

      // A transaction accepted on the halting edge is dropped unjudged.
      s1_valid <= take && !stop_now;
      if (take) begin
        s1_a      <= bus.a;
        s1_b      <= bus.b;
        s1_ctrl   <= bus.alucontrol;
        s1_result <= bus.result;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: three instances (default, STOP_ON_ERR=1, CNT_W=2)
// driven from one stimulus bus, verdicts scored against per-instance expected queues.
module tb_alu_result_checker;

  localparam int W = 32;

  logic clk;
  logic reset;
  logic clear0, clear1, clear2;

  logic         tv_valid;
  int           sel;
  logic [W-1:0] tv_a, tv_b, tv_r;
  logic [2:0]   tv_op;

  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];
  logic [0:0] exp_q2[$];

  int n_vec;
  int n_fail;

  alu_result_checker_if #(.WIDTH(W)) bus0 ();
  alu_result_checker_if #(.WIDTH(W)) bus1 ();
  alu_result_checker_if #(.WIDTH(W)) bus2 ();

  assign bus0.in_valid = tv_valid && (sel == 0);
  assign bus1.in_valid = tv_valid && (sel == 1);
  assign bus2.in_valid = tv_valid && (sel == 2);
  assign bus0.a = tv_a;  assign bus1.a = tv_a;  assign bus2.a = tv_a;
  assign bus0.b = tv_b;  assign bus1.b = tv_b;  assign bus2.b = tv_b;
  assign bus0.result = tv_r;  assign bus1.result = tv_r;  assign bus2.result = tv_r;
  assign bus0.alucontrol = tv_op;  assign bus1.alucontrol = tv_op;  assign bus2.alucontrol = tv_op;

  logic          chk_valid0, chk_pass0, halted0, err_valid0, dbg0;
  logic [15:0]   pass0, fail0, ill0;
  logic [W-1:0]  err_a0, err_b0, err_r0, err_e0;
  logic [2:0]    err_c0;

  logic          chk_valid1, chk_pass1, halted1, err_valid1, dbg1;
  logic [15:0]   pass1, fail1, ill1;
  logic [W-1:0]  err_a1, err_b1, err_r1, err_e1;
  logic [2:0]    err_c1;

  logic          chk_valid2, chk_pass2, halted2, err_valid2, dbg2;
  logic [1:0]    pass2, fail2, ill2;
  logic [W-1:0]  err_a2, err_b2, err_r2, err_e2;
  logic [2:0]    err_c2;

  alu_result_checker #(.WIDTH(W), .CNT_W(16), .STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear0), .bus(bus0.slave),
    .chk_valid(chk_valid0), .chk_pass(chk_pass0), .pass_count(pass0), .fail_count(fail0),
    .illegal_count(ill0), .halted(halted0), .err_valid(err_valid0), .err_a(err_a0),
    .err_b(err_b0), .err_result(err_r0), .err_expected(err_e0), .err_ctrl(err_c0),
    .dbg_state(dbg0)
  );

  alu_result_checker #(.WIDTH(W), .CNT_W(16), .STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear1), .bus(bus1.slave),
    .chk_valid(chk_valid1), .chk_pass(chk_pass1), .pass_count(pass1), .fail_count(fail1),
    .illegal_count(ill1), .halted(halted1), .err_valid(err_valid1), .err_a(err_a1),
    .err_b(err_b1), .err_result(err_r1), .err_expected(err_e1), .err_ctrl(err_c1),
    .dbg_state(dbg1)
  );

  alu_result_checker #(.WIDTH(W), .CNT_W(2), .STOP_ON_ERR(1'b0)) dut2 (
    .clk(clk), .reset(reset), .clear(clear2), .bus(bus2.slave),
    .chk_valid(chk_valid2), .chk_pass(chk_pass2), .pass_count(pass2), .fail_count(fail2),
    .illegal_count(ill2), .halted(halted2), .err_valid(err_valid2), .err_a(err_a2),
    .err_b(err_b2), .err_result(err_r2), .err_expected(err_e2), .err_ctrl(err_c2),
    .dbg_state(dbg2)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic score(input string name, input logic v, input logic p, inout logic [0:0] q[$]);
    logic [0:0] e;
    if (v) begin
      if (q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL %s: got unexpected chk_valid (pass=%0b), required no output", name, p);
      end else begin
        e = q.pop_front();
        check(name, {31'd0, p}, {31'd0, e});
      end
    end
  endtask

  // Driver: present one transaction across one rising edge.
  task automatic drive(input int s, input logic [2:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] vr,
                       input logic exp_pass, input bit push);
    sel = s; tv_valid = 1'b1; tv_op = op; tv_a = va; tv_b = vb; tv_r = vr;
    if (push) begin
      case (s)
        0: exp_q0.push_back(exp_pass);
        1: exp_q1.push_back(exp_pass);
        default: exp_q2.push_back(exp_pass);
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tv_valid = 1'b0;
    tv_a = 'x; tv_b = 'x; tv_r = 'x; tv_op = 'x;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic stream(input int s);
    drive(s, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1, 1'b1);
    drive(s, 3'b001, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b1, 1'b1);
    drive(s, 3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b1);
    drive(s, 3'b011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1);
    drive(s, 3'b101, 32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b1);
    drive(s, 3'b010, 32'h12345678, 32'h11111111, 32'h23456789, 1'b1, 1'b1);
    idle();
  endtask

  initial begin
    int run, max_run, pulses;
    n_vec = 0; n_fail = 0;
    reset = 1'b1; clear0 = 1'b0; clear1 = 1'b0; clear2 = 1'b0;
    sel = 0;
    idle();

    // Monitor: pops the scoreboard whenever an instance presents a verdict.
    fork
      forever begin
        @(negedge clk);
        score("dut0 verdict", chk_valid0, chk_pass0, exp_q0);
        score("dut1 verdict", chk_valid1, chk_pass1, exp_q1);
        score("dut2 verdict", chk_valid2, chk_pass2, exp_q2);
      end
    join_none

    #1;
    check("reset in_ready", {31'd0, bus0.in_ready}, 32'd0);
    check("reset pass_count", {16'd0, pass0}, 32'd0);
    check("reset chk_valid", {31'd0, chk_valid0}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready after reset", {31'd0, bus0.in_ready}, 32'd1);

    // Pass, ADD with latency check
    drive(0, 3'b010, 32'h10000001, 32'hFFFFFFFF, 32'h10000000, 1'b1, 1'b1);
    idle();
    @(negedge clk);
    check("add chk_valid stage1", {31'd0, chk_valid0}, 32'd0);
    @(negedge clk);
    check("add chk_valid", {31'd0, chk_valid0}, 32'd1);
    check("add chk_pass", {31'd0, chk_pass0}, 32'd1);
    check("add pass_count", {16'd0, pass0}, 32'd1);
    check("add fail_count", {16'd0, fail0}, 32'd0);

    // SLT signed: 10 < -1 is false
    drive(0, 3'b101, 32'h0000000A, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
    drive(0, 3'b101, 32'h0000000A, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
    idle();
    settle();
    check("slt pass_count", {16'd0, pass0}, 32'd2);
    check("slt fail_count", {16'd0, fail0}, 32'd1);
    check("slt err_valid", {31'd0, err_valid0}, 32'd1);
    check("slt err_expected", err_e0, 32'h00000000);
    check("slt err_ctrl", {29'd0, err_c0}, 32'd5);
    check("slt err_a", err_a0, 32'h0000000A);
    check("slt err_result", err_r0, 32'h00000001);

    // STOP_ON_ERR: mismatch halts, back-to-back transaction discarded
    drive(1, 3'b000, 32'h1100E000, 32'h1100F001, 32'h1100F001, 1'b0, 1'b1);
    drive(1, 3'b010, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    idle();
    settle();
    check("halt fail_count", {16'd0, fail1}, 32'd1);
    check("halt pass_count", {16'd0, pass1}, 32'd0);
    check("halt halted", {31'd0, halted1}, 32'd1);
    check("halt in_ready", {31'd0, bus1.in_ready}, 32'd0);
    check("halt err_expected", err_e1, 32'h1100E000);
    clear1 = 1'b1;
    @(posedge clk);
    #1;
    clear1 = 1'b0;
    @(negedge clk);
    check("clear fail_count", {16'd0, fail1}, 32'd0);
    check("clear halted", {31'd0, halted1}, 32'd0);
    check("clear err_valid", {31'd0, err_valid1}, 32'd0);
    check("clear in_ready", {31'd0, bus1.in_ready}, 32'd1);
    drive(1, 3'b010, 32'h00000001, 32'h00000002, 32'h00000003, 1'b1, 1'b1);
    idle();
    settle();
    check("resume pass_count", {16'd0, pass1}, 32'd1);

    // Illegal opcode
    drive(2, 3'b111, 32'h11111111, 32'h11111111, 32'h22222222, 1'b0, 1'b1);
    idle();
    settle();
    check("illegal count", {30'd0, ill2}, 32'd1);
    check("illegal pass_count", {30'd0, pass2}, 32'd0);
    check("illegal fail_count", {30'd0, fail2}, 32'd0);
    check("illegal err_valid", {31'd0, err_valid2}, 32'd0);

    // Streaming: six back-to-back verdicts
    run = 0; max_run = 0; pulses = 0;
    fork
      stream(0);
      repeat (12) begin
        @(negedge clk);
        if (chk_valid0) begin
          run++; pulses++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
      end
    join
    check("stream pulses", pulses, 32'd6);
    check("stream consecutive", max_run, 32'd6);
    check("stream pass_count", {16'd0, pass0}, 32'd8);
    check("stream fail_count", {16'd0, fail0}, 32'd1);

    // Saturation with 2-bit counters
    stream(2);
    settle();
    check("sat pass_count", {30'd0, pass2}, 32'd3);
    check("sat illegal_count", {30'd0, ill2}, 32'd1);

    // Asynchronous reset while stage 1 is occupied
    drive(0, 3'b001, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b1, 1'b0);
    idle();
    #2;
    reset = 1'b1;
    #1;
    check("areset pass_count", {16'd0, pass0}, 32'd0);
    check("areset fail_count", {16'd0, fail0}, 32'd0);
    check("areset chk_pass", {31'd0, chk_pass0}, 32'd0);
    check("areset err_valid", {31'd0, err_valid0}, 32'd0);
    check("areset err_a", err_a0, 32'd0);
    check("areset in_ready", {31'd0, bus0.in_ready}, 32'd0);
    check("areset sat counter", {30'd0, pass2}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post-reset pass_count", {16'd0, pass0}, 32'd0);
    drive(0, 3'b011, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b1);
    idle();
    settle();
    check("post-reset count", {16'd0, pass0}, 32'd1);

    check("dut0 queue drained", exp_q0.size(), 32'd0);
    check("dut1 queue drained", exp_q1.size(), 32'd0);
    check("dut2 queue drained", exp_q2.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
